bcd_display_scan: RTL
=====================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000: cycles each digit anode is driven on.
REQ-002 SHALL have parameter GUARD, default 16: all-anodes-off cycles before each digit (anti-ghosting).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port bcd_in  input  12  three BCD digits from the ALU/selector stage: [3:0] ones, [7:4] tens, [11:8] hundreds.
REQ-006 SHALL have port bcd_valid  input  1  bcd_in is offered this cycle.
REQ-007 SHALL have port bcd_ready  output  1  the block accepts bcd_in this cycle.
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dig_an  output  3  digit anodes, active-low: [0] ones, [1] tens, [2] hundreds.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse on the first GUARD cycle of digit 0.

Function
REQ-011 SHALL accept bcd_in into a pending register on any cycle where bcd_valid && bcd_ready.
REQ-012 SHALL drive bcd_ready = !pending_full, combinationally from registered state only.
REQ-013 SHALL move pending into the display register on the frame_start cycle, then clear pending_full; a new value is accepted no earlier than the next cycle.
REQ-014 SHALL ignore bcd_valid while bcd_ready is low; the offered data is not captured.
REQ-015 SHALL run an FSM G0 -> D0 -> G1 -> D1 -> G2 -> D2 -> G0; Gx lasts GUARD cycles, Dx lasts CLK_DIV cycles; frame = 3*(GUARD+CLK_DIV) cycles.
REQ-016 SHALL skip Gx states when GUARD = 0.
REQ-017 SHALL use one down-counter, reloaded on every state transition, to time all states.
REQ-018 SHALL drive dig_an = 3'b111 and seg = 7'h7F in every Gx state.
REQ-019 SHALL, in Dx, drive only bit x of dig_an low, with seg = decode(digit x of the display register).
REQ-020 SHALL decode 0-9 to standard active-low patterns: 0 = 7'h40, 1 = 7'h79, 8 = 7'h00.
REQ-021 SHALL decode nibbles 10-15 to 'E' (7'h06).
REQ-022 SHALL register seg and dig_an so that they are glitch-free.
REQ-023 SHALL make seg and dig_an change in the same cycle, one cycle after the FSM state changes.
REQ-024 SHALL give a value accepted just after frame_start a display latency of at most one frame plus one cycle.

Reset
REQ-025 SHALL, on rst_n low, immediately set seg = 7'h7F and dig_an = 3'b111.
REQ-026 SHALL, on rst_n low, set display register = 0, pending_full = 0, bcd_ready = 1, frame_start = 0, FSM = G0, and counter = GUARD.
REQ-027 SHALL, after reset is released mid-frame, start a fresh frame; frame_start pulses on the first clock edge after release.

Configuration
REQ-028 SHALL, with LEADING_ZERO_BLANK_EN defined, show the hundreds digit blank when it is 0.
REQ-029 SHALL, with LEADING_ZERO_BLANK_EN defined, show the tens digit blank when both hundreds and tens are 0.
REQ-030 SHALL, with LEADING_ZERO_BLANK_EN defined, never blank the ones digit.
REQ-031 SHALL, with LEADING_ZERO_BLANK_EN defined, still assert the anode of a blanked digit while driving seg = 7'h7F.
REQ-032 SHALL, without LEADING_ZERO_BLANK_EN, show all digits, including 0, at all times.

Structure
REQ-033 SHALL place the FSM state enum and segment constants (SEG_BLANK, SEG_E, digit table) in shared package disp_pkg.
REQ-034 SHALL implement nibble-to-segment decoding in combinational sub-module bcd_to_seg, instantiated once and muxed by FSM state.

Verification (CLK_DIV = 4, GUARD = 1)
REQ-035 SHALL verify: reset, then 15 cycles idle -> frame_start pulses every 15 cycles; during D0 dig_an = 3'b110 and seg = 7'h40.
REQ-036 SHALL verify: bcd_in = 12'h123 valid for 1 cycle -> bcd_ready low until next frame_start; next frame shows D0 = 3 (7'h30), D1 = 2 (7'h24), D2 = 1 (7'h79).
REQ-037 SHALL verify: two values offered back-to-back with valid held -> second is captured only after frame_start clears pending; no value is lost or duplicated.
REQ-038 SHALL verify: bcd_in = 12'h0A5 -> tens digit shows 7'h06.
REQ-039 SHALL verify: with LEADING_ZERO_BLANK_EN, bcd_in = 12'h007 -> D2 and D1 show seg = 7'h7F with anode low; D0 shows 7'h78.
REQ-040 SHALL verify: rst_n pulled low during D1 -> seg = 7'h7F and dig_an = 3'b111 in the same cycle; after release, frame_start occurs on the first clock edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and segment constants for the three-digit BCD display scanner.
// Segment bit order is {g,f,e,d,c,b,a}, all patterns active-low.
`timescale 1ns/1ps
package disp_pkg;

    typedef enum logic [2:0] {
        ST_G0 = 3'd0,
        ST_D0 = 3'd1,
        ST_G1 = 3'd2,
        ST_D1 = 3'd3,
        ST_G2 = 3'd4,
        ST_D2 = 3'd5
    } disp_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;

    // Digit table, 0 through 9.
    localparam logic [6:0] SEG_DIG0 = 7'h40;
    localparam logic [6:0] SEG_DIG1 = 7'h79;
    localparam logic [6:0] SEG_DIG2 = 7'h24;
    localparam logic [6:0] SEG_DIG3 = 7'h30;
    localparam logic [6:0] SEG_DIG4 = 7'h19;
    localparam logic [6:0] SEG_DIG5 = 7'h12;
    localparam logic [6:0] SEG_DIG6 = 7'h02;
    localparam logic [6:0] SEG_DIG7 = 7'h78;
    localparam logic [6:0] SEG_DIG8 = 7'h00;
    localparam logic [6:0] SEG_DIG9 = 7'h10;

    localparam logic [2:0] AN_OFF = 3'b111;

    function automatic logic [2:0] anode_for(input logic [1:0] idx);
        logic [2:0] an;
        case (idx)
            2'd0:    an = 3'b110;
            2'd1:    an = 3'b101;
            2'd2:    an = 3'b011;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational nibble to seven-segment decoder; non-decimal nibbles show 'E'.
`timescale 1ns/1ps
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the active-low pattern for one nibble.
    always_comb begin
        seg = SEG_E;
        case (nibble)
            4'd0:    seg = SEG_DIG0;
            4'd1:    seg = SEG_DIG1;
            4'd2:    seg = SEG_DIG2;
            4'd3:    seg = SEG_DIG3;
            4'd4:    seg = SEG_DIG4;
            4'd5:    seg = SEG_DIG5;
            4'd6:    seg = SEG_DIG6;
            4'd7:    seg = SEG_DIG7;
            4'd8:    seg = SEG_DIG8;
            4'd9:    seg = SEG_DIG9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed three-digit seven-segment scanner with guard gaps and a one-deep input buffer.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros of the hundreds/tens digits.
`timescale 1ns/1ps
module bcd_display_scan
    import disp_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1000,
    parameter int unsigned GUARD   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    output logic [6:0]  seg,
    output logic [2:0]  dig_an,
    output logic        frame_start
);

    localparam int unsigned MAX_DUR = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
    localparam int unsigned CW      = $clog2(MAX_DUR + 1);
    localparam logic [CW-1:0] CNT_DIV   = CW'(CLK_DIV);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZB_EN = 1'b1;
`else
    localparam logic LZB_EN = 1'b0;
`endif

    disp_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   pending_q, pending_d;
    logic          pending_full_q, pending_full_d;
    logic [11:0]   display_q, display_d;
    logic          frame_start_q, frame_start_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    dig_an_q, dig_an_d;

    logic [3:0]    nibble_s;
    logic [6:0]    dec_seg_s;
    logic [2:0]    an_s;
    logic          guard_s;
    logic          blank_s;

    assign bcd_ready   = !pending_full_q;
    assign seg         = seg_q;
    assign dig_an      = dig_an_q;
    assign frame_start = frame_start_q;

    // Scan sequencer: a single down-counter times every state and is reloaded on each transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
            case (state_q)
                ST_G0:   state_d = ST_D0;
                ST_D0:   state_d = (GUARD == 0) ? ST_D1 : ST_G1;
                ST_G1:   state_d = ST_D1;
                ST_D1:   state_d = (GUARD == 0) ? ST_D2 : ST_G2;
                ST_G2:   state_d = ST_D2;
                ST_D2:   state_d = (GUARD == 0) ? ST_D0 : ST_G0;
                default: state_d = ST_G0;
            endcase
            cnt_d = (state_d inside {ST_G0, ST_G1, ST_G2}) ? CNT_GUARD : CNT_DIV;
        end else begin
            state_d = state_q;
        end
    end

    // Frame marker aligned with the registered outputs, so it lags the state by one cycle.
    always_comb begin
        if (GUARD == 0) begin
            frame_start_d = (state_q == ST_D0) && (cnt_q == CNT_DIV);
        end else begin
            frame_start_d = (state_q == ST_G0) && (cnt_q == CNT_GUARD);
        end
    end

    // Input buffer: capture while empty, hand over to the display at the end of the frame_start cycle.
    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        display_d      = display_q;
        if (frame_start_q && pending_full_q) begin
            display_d      = pending_q;
            pending_full_d = 1'b0;
        end else if (bcd_valid && !pending_full_q) begin
            pending_d      = bcd_in;
            pending_full_d = 1'b1;
        end else begin
            pending_full_d = pending_full_q;
        end
    end

    // Digit selection; display_d is used so a freshly moved value shows from the first D0 cycle.
    always_comb begin
        nibble_s = 4'd0;
        an_s     = AN_OFF;
        guard_s  = 1'b1;
        blank_s  = 1'b0;
        case (state_q)
            ST_D0: begin
                nibble_s = display_d[3:0];
                an_s     = anode_for(2'd0);
                guard_s  = 1'b0;
            end
            ST_D1: begin
                nibble_s = display_d[7:4];
                an_s     = anode_for(2'd1);
                guard_s  = 1'b0;
                blank_s  = LZB_EN && (display_d[11:8] == 4'd0) && (display_d[7:4] == 4'd0);
            end
            ST_D2: begin
                nibble_s = display_d[11:8];
                an_s     = anode_for(2'd2);
                guard_s  = 1'b0;
                blank_s  = LZB_EN && (display_d[11:8] == 4'd0);
            end
            default: begin
                guard_s = 1'b1;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble (nibble_s),
        .seg    (dec_seg_s)
    );

    // Output pattern for the current state, registered below.
    always_comb begin
        seg_d    = SEG_BLANK;
        dig_an_d = AN_OFF;
        if (guard_s) begin
            seg_d    = SEG_BLANK;
            dig_an_d = AN_OFF;
        end else if (blank_s) begin
            seg_d    = SEG_BLANK;
            dig_an_d = an_s;
        end else begin
            seg_d    = dec_seg_s;
            dig_an_d = an_s;
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_G0;
            cnt_q          <= CNT_GUARD;
            pending_q      <= 12'h000;
            pending_full_q <= 1'b0;
            display_q      <= 12'h000;
            frame_start_q  <= 1'b0;
            seg_q          <= SEG_BLANK;
            dig_an_q       <= AN_OFF;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            display_q      <= display_d;
            frame_start_q  <= frame_start_d;
            seg_q          <= seg_d;
            dig_an_q       <= dig_an_d;
        end
    end

endmodule
